load_store_unit: RTL and testbench

- Initiator side of the word-addressed data-memory interface (wren/rden/addr/d/q).
- Accepts byte-addressed RV64 load/store requests from the pipeline over a valid/ready handshake and converts them into 64-bit word accesses.
- Performs byte-lane extraction with sign or zero extension, and read-modify-write for sub-word stores.
- Returns one response per request, with an error flag for misaligned or out-of-range addresses.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_align.sv | 46 ++++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 tb/tb_load_store_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   SZ_*        : access size encodings carried on req_size
//   lsu_state_e : LSU control states
//   size_bytes  : number of bytes touched by an access of a given size
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for 64-bit memory words (purely combinational).
//   ext_word, off, size, is_unsigned -> ext_data : lane extraction with
//                                                  sign/zero extension
//   mrg_word, off, size, wdata       -> mrg_data : lane replacement for
//                                                  sub-word stores
import lsu_pkg::*;

module lsu_align (
    input  logic [63:0] ext_word,
    input  logic [63:0] mrg_word,
    input  logic [2:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [63:0] wdata,
    output logic [63:0] ext_data,
    output logic [63:0] mrg_data
);

    logic [63:0] shifted;
    logic [63:0] bmask;
    logic [3:0]  nbytes;

    always_comb begin
        shifted = ext_word >> {off, 3'b000};
        unique case (size)
            SZ_B:    ext_data = is_unsigned ? {56'd0, shifted[7:0]}
                                            : {{56{shifted[7]}}, shifted[7:0]};
            SZ_H:    ext_data = is_unsigned ? {48'd0, shifted[15:0]}
                                            : {{48{shifted[15]}}, shifted[15:0]};
            SZ_W:    ext_data = is_unsigned ? {32'd0, shifted[31:0]}
                                            : {{32{shifted[31]}}, shifted[31:0]};
            default: ext_data = shifted;
        endcase
    end

    // Byte enable per lane: lanes off .. off+nbytes-1 take the store data.
    always_comb begin
        nbytes = size_bytes(size);
        for (int i = 0; i < 8; i++) begin
            bmask[i*8 +: 8] = (i >= int'(off) && i < int'(off) + int'(nbytes))
                              ? 8'hFF : 8'h00;
        end
        mrg_data = (mrg_word & ~bmask) | ((wdata << {off, 3'b000}) & bmask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed RV64 load/store requests into
// 64-bit word accesses on a combinational data memory.
//   clk, rst            : clock, synchronous active-high reset
//   req_*               : request handshake (one outstanding request)
//   rsp_*               : response handshake, data and error flag
//   mem_wren/rden/addr/d: word-addressed memory command, mem_q read data
// Sub-word stores are done as read-modify-write (READ then WRITE).
import lsu_pkg::*;

module load_store_unit #(
    parameter int XLEN   = 64,
    parameter int MEM_AW = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              mem_wren,
    output logic              mem_rden,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_d,
    input  logic [XLEN-1:0]   mem_q
);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [MEM_AW-1:0] idx_q, idx_d;
    logic [2:0]        off_q, off_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   buf_q, buf_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              misaligned, out_of_range;
    logic [2:0]        low_mask;
    logic [XLEN-1:0]   ext_data, mrg_data;

    lsu_align u_align (
        .ext_word    (mem_q),
        .mrg_word    (buf_q),
        .off         (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .ext_data    (ext_data),
        .mrg_data    (mrg_data)
    );

    always_comb begin
        low_mask     = 3'(size_bytes(req_size) - 4'd1);
        misaligned   = (req_addr[2:0] & low_mask) != 3'd0;
        out_of_range = req_addr[XLEN-1:MEM_AW+3] != '0;

        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        idx_d   = idx_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: if (req_valid) begin
                we_d    = req_we;
                size_d  = req_size;
                uns_d   = req_unsigned;
                idx_d   = req_addr[MEM_AW+2:3];
                off_d   = req_addr[2:0];
                wdata_d = req_wdata;
                rdata_d = '0;
                err_d   = misaligned | out_of_range;
                if (misaligned | out_of_range)        state_d = RESP;
                else if (req_we && req_size == SZ_D)  state_d = WRITE;
                else                                  state_d = READ;
            end
            READ: begin
                buf_d = mem_q;
                if (we_q) begin
                    state_d = WRITE;
                end else begin
                    rdata_d = ext_data;
                    state_d = RESP;
                end
            end
            WRITE: state_d = RESP;
            RESP:  if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            idx_q   <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Everything below depends on registered state only, never on req_*.
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_rden  = (state_q == READ);
    assign mem_wren  = (state_q == WRITE);
    assign mem_addr  = (state_q == READ || state_q == WRITE) ? idx_q : '0;
    assign mem_d     = (state_q == WRITE) ? mrg_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_wren, mem_rden;
    logic [5:0]  mem_addr;
    logic [63:0] mem_d, mem_q;

    logic [63:0] mem [0:63] = '{default: 64'd0};
    logic        bd_we = 1'b0;
    logic [5:0]  bd_addr = 6'd0;
    logic [63:0] bd_data = 64'd0;

    int errors = 0;
    int checks = 0;
    int wr_total = 0;
    int viol = 0;
    int rd_cnt, wr_cnt;
    logic [63:0] last_d;
    logic [5:0]  last_a;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(64), .MEM_AW(6)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_addr(mem_addr),
        .mem_d(mem_d), .mem_q(mem_q)
    );

    // Combinational memory with a backdoor write port for preloading.
    assign mem_q = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_wren) begin
            mem[mem_addr] <= mem_d;
            wr_total <= wr_total + 1;
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end
    end

    // Memory command sanity: never read+write together, mem_d zero unless writing.
    always @(negedge clk) begin
        if (!rst && ((mem_wren && mem_rden) || (!mem_wren && mem_d != 64'd0)))
            viol <= viol + 1;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic poke(input logic [5:0] a, input logic [63:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Issue one request and collect the response. With hold>0 the response
    // is back-pressured for hold cycles while another request is offered;
    // in that case req_valid is left high on return.
    task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [63:0] a, input logic [63:0] wd, input int hold,
                           output int lat, output logic [63:0] rd, output logic er);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd; rsp_ready = 1'b0;
        rd_cnt = 0; wr_cnt = 0; last_d = 64'd0; last_a = 6'd0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            if (mem_rden) begin rd_cnt++; last_a = mem_addr; end
            if (mem_wren) begin wr_cnt++; last_a = mem_addr; last_d = mem_d; end
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        if (hold > 0) begin
            req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_unsigned = 1'b0;
            req_addr = 64'h18; req_wdata = 64'd0;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                chk("bp.rsp_valid", {63'd0, rsp_valid}, 64'd1);
                chk("bp.rdata", rsp_rdata, rd);
                chk("bp.err", {63'd0, rsp_err}, {63'd0, er});
                chk("bp.req_ready", {63'd0, req_ready}, 64'd0);
                chk("bp.mem_idle", {62'd0, mem_rden, mem_wren}, 64'd0);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic vec(input string tag, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [63:0] a, input logic [63:0] wd,
                       input int e_lat, input logic [63:0] e_rd, input logic e_err,
                       input int e_rds, input int e_wrs, input logic [5:0] e_addr,
                       input logic [63:0] e_d);
        int lat; logic [63:0] rd; logic er;
        run_req(we, sz, uns, a, wd, 0, lat, rd, er);
        chk({tag, ".lat"}, 64'(lat), 64'(e_lat));
        chk({tag, ".rdata"}, rd, e_rd);
        chk({tag, ".err"}, {63'd0, er}, {63'd0, e_err});
        chk({tag, ".pulses"}, {32'(rd_cnt), 32'(wr_cnt)}, {32'(e_rds), 32'(e_wrs)});
        if (e_rds + e_wrs > 0) chk({tag, ".addr"}, {58'd0, last_a}, {58'd0, e_addr});
        chk({tag, ".mem_d"}, last_d, e_d);
        chk({tag, ".idle"}, {62'd0, req_ready, rsp_valid}, 64'd2);
    endtask

    initial begin
        int lat; logic [63:0] rd; logic er; int wsnap;

        repeat (3) @(negedge clk);
        chk("rst.rsp", {rsp_valid, rsp_err, 62'd0}, 64'd0);
        chk("rst.rdata", rsp_rdata, 64'd0);
        chk("rst.mem", {mem_wren, mem_rden, 56'd0, mem_addr}, 64'd0);
        chk("rst.mem_d", mem_d, 64'd0);
        chk("rst.req_ready", {63'd0, req_ready}, 64'd1);
        rst = 1'b0;

        poke(6'd3, 64'h8877_6655_4433_2211);
        poke(6'd63, 64'hA5A5_5A5A_0F0F_F0F0);

        // loads: tag we sz uns addr wdata lat rdata err rds wrs addr mem_d
        vec("lb",   0, 2'd0, 0, 64'h1F, 0, 2, 64'hFFFF_FFFF_FFFF_FF88, 0, 1, 0, 6'd3, 0);
        vec("lbu",  0, 2'd0, 1, 64'h1F, 0, 2, 64'h0000_0000_0000_0088, 0, 1, 0, 6'd3, 0);
        vec("lhu",  0, 2'd1, 1, 64'h1C, 0, 2, 64'h0000_0000_0000_6655, 0, 1, 0, 6'd3, 0);
        vec("lh",   0, 2'd1, 0, 64'h1E, 0, 2, 64'hFFFF_FFFF_FFFF_8877, 0, 1, 0, 6'd3, 0);
        vec("lw0",  0, 2'd2, 0, 64'h18, 0, 2, 64'h0000_0000_4433_2211, 0, 1, 0, 6'd3, 0);
        vec("lw4",  0, 2'd2, 0, 64'h1C, 0, 2, 64'hFFFF_FFFF_8877_6655, 0, 1, 0, 6'd3, 0);
        vec("lwu",  0, 2'd2, 1, 64'h1C, 0, 2, 64'h0000_0000_8877_6655, 0, 1, 0, 6'd3, 0);
        vec("ld",   0, 2'd3, 1, 64'h18, 0, 2, 64'h8877_6655_4433_2211, 0, 1, 0, 6'd3, 0);
        vec("ldtop",0, 2'd3, 0, 64'h1F8, 0, 2, 64'hA5A5_5A5A_0F0F_F0F0, 0, 1, 0, 6'd63, 0);

        // stores
        vec("sw",   1, 2'd2, 0, 64'h14, 64'hDEAD_BEEF, 3, 0, 0, 1, 1, 6'd2, 64'hDEAD_BEEF_0000_0000);
        chk("sw.mem", mem[2], 64'hDEAD_BEEF_0000_0000);
        vec("sb",   1, 2'd0, 0, 64'h11, 64'h12_34AB, 3, 0, 0, 1, 1, 6'd2, 64'hDEAD_BEEF_0000_AB00);
        vec("sh",   1, 2'd1, 0, 64'h16, 64'hFFFF_CAFE, 3, 0, 0, 1, 1, 6'd2, 64'hCAFE_BEEF_0000_AB00);
        chk("sh.mem", mem[2], 64'hCAFE_BEEF_0000_AB00);
        vec("sd",   1, 2'd3, 0, 64'h28, 64'h0123_4567_89AB_CDEF, 2, 0, 0, 0, 1, 6'd5, 64'h0123_4567_89AB_CDEF);
        chk("sd.mem", mem[5], 64'h0123_4567_89AB_CDEF);

        // errors
        vec("mis_lw", 0, 2'd2, 0, 64'h6, 0, 1, 0, 1, 0, 0, 6'd0, 0);
        vec("oor_lb", 0, 2'd0, 0, 64'h200, 0, 1, 0, 1, 0, 0, 6'd0, 0);
        vec("oor_hi", 0, 2'd3, 0, 64'h8000_0000_0000_0000, 0, 1, 0, 1, 0, 0, 6'd0, 0);
        vec("mis_sh", 1, 2'd1, 0, 64'h3, 64'hFFFF, 1, 0, 1, 0, 0, 6'd0, 0);
        chk("mis_sh.mem", mem[0], 64'd0);
        vec("mis_sd", 1, 2'd3, 0, 64'h2C, 64'h1, 1, 0, 1, 0, 0, 6'd0, 0);
        chk("mis_sd.mem", mem[5], 64'h0123_4567_89AB_CDEF);

        // backpressure on a load, with a second request waiting
        run_req(0, 2'd1, 0, 64'h1E, 0, 5, lat, rd, er);
        chk("bp.lat", 64'(lat), 64'd2);
        chk("bp.first", rd, 64'hFFFF_FFFF_FFFF_8877);
        chk("bp.released", {62'd0, req_ready, rsp_valid}, 64'd2);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp.second_read", {58'd0, mem_rden, mem_addr}, {58'd0, 1'b1, 6'd3});
        lat = 0;
        while (!rsp_valid && lat < 10) begin @(negedge clk); lat++; end
        chk("bp.second_lat", 64'(lat), 64'd1);
        chk("bp.second", rsp_rdata, 64'h8877_6655_4433_2211);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // reset in READ of a sub-word store
        poke(6'd6, 64'h1111_1111_1111_1111);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 64'h30; req_wdata = 64'hFF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rmid.in_read", {63'd0, mem_rden}, 64'd1);
        rst = 1'b1;
        wsnap = wr_total;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rmid.rsp", {rsp_valid, rsp_err, 62'd0}, 64'd0);
        chk("rmid.rdata", rsp_rdata, 64'd0);
        chk("rmid.mem", {mem_wren, mem_rden, 56'd0, mem_addr}, 64'd0);
        chk("rmid.mem_d", mem_d, 64'd0);
        chk("rmid.req_ready", {63'd0, req_ready}, 64'd1);
        repeat (4) @(negedge clk);
        chk("rmid.no_write", 64'(wr_total), 64'(wsnap));
        chk("rmid.mem", mem[6], 64'h1111_1111_1111_1111);

        chk("mem_cmd_rules", 64'(viol), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
